if_id_stage_ctrl: RTL and testbench

IF/ID pipeline register with integrated stall/flush control for the 5-stage MIPS32 pipeline. It captures the fetched PC and instruction, and feeds IF_ID_RsAddr/IF_ID_RtAddr to the load-use hazard detector. It consumes that detector's LdUseHazard output, together with jump (ID) and taken-branch (EX) redirects. It drives the PC write enable and the ID/EX bubble request, and keeps a stall watchdog and performance counters.

---
 rtl/if_id_stage_ctrl.sv | 117 +++++++++++
 tb/tb_if_id_stage_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_ctrl.sv
// IF/ID pipeline register with load-use stall, jump/branch flush control,
// a consecutive-stall watchdog and saturating stall/flush counters.
module if_id_stage_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          MAX_STALL = 1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IF_PC,
  input  logic [31:0]      IF_Instr,
  input  logic             LdUseHazard,
  input  logic             ID_Jump,
  input  logic             EX_BranchTaken,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic [31:0]      IF_ID_Instr,
  output logic             IF_ID_Valid,
  output logic [4:0]       IF_ID_RsAddr,
  output logic [4:0]       IF_ID_RtAddr,
  output logic             PC_Write,
  output logic             ID_EX_Bubble,
  output logic             StallErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Consecutive-stall counter only needs to reach MAX_STALL+1, then it parks.
  localparam int             CW         = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0]  CONSEC_SAT = CW'(MAX_STALL + 1);
  localparam logic [CW-1:0]  CONSEC_LIM = CW'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0]    consec_q, consec_d;

  logic stall;
  logic stall_cycle;

  assign stall       = LdUseHazard & valid_q;
  assign stall_cycle = stall & ~EX_BranchTaken;

  always_comb begin
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    scnt_d   = scnt_q;
    fcnt_d   = fcnt_q;
    consec_d = consec_q;
    err_d    = err_q;

    // Taken branch outranks the stall; a held slot would be squashed anyway.
    if (EX_BranchTaken || (!stall && ID_Jump)) begin
      pc_d    = IF_PC;
      pc4_d   = IF_PC + 32'd4;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + 1'b1;
    end else if (stall) begin
      if (scnt_q != CNT_MAX) scnt_d = scnt_q + 1'b1;
    end else begin
      pc_d    = IF_PC;
      pc4_d   = IF_PC + 32'd4;
      instr_d = IF_Instr;
      valid_d = 1'b1;
    end

    if (stall_cycle) begin
      if (consec_q != CONSEC_SAT) consec_d = consec_q + 1'b1;
      if (consec_q >= CONSEC_LIM) err_d = 1'b1;
    end else begin
      consec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= 32'd0;
      pc4_q    <= 32'd4;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      scnt_q   <= '0;
      fcnt_q   <= '0;
      consec_q <= '0;
    end else begin
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      scnt_q   <= scnt_d;
      fcnt_q   <= fcnt_d;
      consec_q <= consec_d;
    end
  end

  assign IF_ID_PC      = pc_q;
  assign IF_ID_PCPlus4 = pc4_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_Valid   = valid_q;
  assign IF_ID_RsAddr  = instr_q[25:21];
  assign IF_ID_RtAddr  = instr_q[20:16];
  assign PC_Write      = ~stall_cycle;
  assign ID_EX_Bubble  = EX_BranchTaken | stall;
  assign StallErr      = err_q;
  assign StallCnt      = scnt_q;
  assign FlushCnt      = fcnt_q;

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Randomized and directed bench for if_id_stage_ctrl against a cycle-level
// reference model; counters are built 4 bits wide so saturation is reachable.
module tb_if_id_stage_ctrl;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      IF_PC;
  logic [31:0]      IF_Instr;
  logic             LdUseHazard;
  logic             ID_Jump;
  logic             EX_BranchTaken;
  logic [31:0]      IF_ID_PC;
  logic [31:0]      IF_ID_PCPlus4;
  logic [31:0]      IF_ID_Instr;
  logic             IF_ID_Valid;
  logic [4:0]       IF_ID_RsAddr;
  logic [4:0]       IF_ID_RtAddr;
  logic             PC_Write;
  logic             ID_EX_Bubble;
  logic             StallErr;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  int testsRun  = 0;
  int testsFail = 0;

  // Reference model state: what the IF/ID stage should hold.
  logic [31:0] mPc, mPc4, mInstr;
  bit          mValid, mErr;
  int          mStallCnt, mFlushCnt, mRunLen;

  always #5 clk = ~clk;

  if_id_stage_ctrl #(
    .NOP_INSTR(32'h0000_0000),
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_PC         (IF_PC),
    .IF_Instr      (IF_Instr),
    .LdUseHazard   (LdUseHazard),
    .ID_Jump       (ID_Jump),
    .EX_BranchTaken(EX_BranchTaken),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_Valid   (IF_ID_Valid),
    .IF_ID_RsAddr  (IF_ID_RsAddr),
    .IF_ID_RtAddr  (IF_ID_RtAddr),
    .PC_Write      (PC_Write),
    .ID_EX_Bubble  (ID_EX_Bubble),
    .StallErr      (StallErr),
    .StallCnt      (StallCnt),
    .FlushCnt      (FlushCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the priority rules.
  task automatic modelEdge();
    bit stallNow;
    if (!rst_n) begin
      mPc = 32'd0; mPc4 = 32'd4; mInstr = 32'd0; mValid = 0;
      mErr = 0; mStallCnt = 0; mFlushCnt = 0; mRunLen = 0;
      return;
    end
    stallNow = LdUseHazard && mValid;
    if (EX_BranchTaken || (ID_Jump && !stallNow)) begin
      mPc = IF_PC; mPc4 = IF_PC + 32'd4; mInstr = 32'd0; mValid = 0;
      mFlushCnt = (mFlushCnt < CNT_MAX) ? mFlushCnt + 1 : CNT_MAX;
      mRunLen = 0;
    end else if (stallNow) begin
      mStallCnt = (mStallCnt < CNT_MAX) ? mStallCnt + 1 : CNT_MAX;
      mRunLen++;
      if (mRunLen > MAX_STALL) mErr = 1;
    end else begin
      mPc = IF_PC; mPc4 = IF_PC + 32'd4; mInstr = IF_Instr; mValid = 1;
      mRunLen = 0;
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check state.
  task automatic applyStimulus(input bit rst, input logic [31:0] pc,
                               input logic [31:0] instr, input bit ld,
                               input bit jmp, input bit br);
    bit stallNow;
    @(negedge clk);
    rst_n = rst; IF_PC = pc; IF_Instr = instr;
    LdUseHazard = ld; ID_Jump = jmp; EX_BranchTaken = br;
    #1;
    stallNow = ld && mValid;
    checkOutput("PC_Write", {31'd0, PC_Write}, {31'd0, !(stallNow && !br)});
    checkOutput("ID_EX_Bubble", {31'd0, ID_EX_Bubble}, {31'd0, (br || stallNow)});
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("IF_ID_PC", IF_ID_PC, mPc);
    checkOutput("IF_ID_PCPlus4", IF_ID_PCPlus4, mPc4);
    checkOutput("IF_ID_Instr", IF_ID_Instr, mInstr);
    checkOutput("IF_ID_Valid", {31'd0, IF_ID_Valid}, {31'd0, mValid});
    checkOutput("IF_ID_RsAddr", {27'd0, IF_ID_RsAddr}, {27'd0, mInstr[25:21]});
    checkOutput("IF_ID_RtAddr", {27'd0, IF_ID_RtAddr}, {27'd0, mInstr[20:16]});
    checkOutput("StallErr", {31'd0, StallErr}, {31'd0, mErr});
    checkOutput("StallCnt", {28'd0, StallCnt}, 32'(mStallCnt));
    checkOutput("FlushCnt", {28'd0, FlushCnt}, 32'(mFlushCnt));
  endtask

  task automatic normalCycle(input logic [31:0] pc);
    applyStimulus(1, pc, $urandom, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; IF_PC = 0; IF_Instr = 0;
    LdUseHazard = 0; ID_Jump = 0; EX_BranchTaken = 0;
    mPc = 0; mPc4 = 4; mInstr = 0; mValid = 0; mErr = 0;
    mStallCnt = 0; mFlushCnt = 0; mRunLen = 0;

    // Reset with random inputs
    repeat (2) applyStimulus(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    checkOutput("rst_instr", IF_ID_Instr, 32'd0);
    checkOutput("rst_stallcnt", {28'd0, StallCnt}, 32'd0);
    checkOutput("rst_err", {31'd0, StallErr}, 32'd0);

    // First normal edge
    applyStimulus(1, 32'h0040_0000, 32'h8D09_0004, 0, 0, 0);
    checkOutput("first_pc4", IF_ID_PCPlus4, 32'h0040_0004);
    checkOutput("first_rs", {27'd0, IF_ID_RsAddr}, 32'd8);
    checkOutput("first_rt", {27'd0, IF_ID_RtAddr}, 32'd9);
    checkOutput("first_valid", {31'd0, IF_ID_Valid}, 32'd1);

    // Single load-use stall holds the slot
    applyStimulus(1, 32'h0040_0004, 32'h0128_5020, 1, 0, 0);
    checkOutput("stall_hold_instr", IF_ID_Instr, 32'h8D09_0004);
    checkOutput("stall_cnt1", {28'd0, StallCnt}, 32'd1);
    checkOutput("stall_noerr", {31'd0, StallErr}, 32'd0);
    applyStimulus(1, 32'h0040_0004, 32'h0128_5020, 0, 0, 0);
    checkOutput("stall_advance", IF_ID_Instr, 32'h0128_5020);

    // Two consecutive stalls trip the watchdog, which stays set
    applyStimulus(1, 32'h0040_0008, $urandom, 1, 0, 0);
    applyStimulus(1, 32'h0040_0008, $urandom, 1, 0, 0);
    checkOutput("wd_set", {31'd0, StallErr}, 32'd1);
    normalCycle(32'h0040_0008);
    checkOutput("wd_sticky", {31'd0, StallErr}, 32'd1);

    // Branch beats stall and jump
    applyStimulus(0, 0, 0, 0, 0, 0);
    normalCycle(32'h0040_0100);
    applyStimulus(1, 32'h0040_0104, $urandom, 1, 1, 1);
    checkOutput("br_valid", {31'd0, IF_ID_Valid}, 32'd0);
    checkOutput("br_flushcnt", {28'd0, FlushCnt}, 32'd1);
    checkOutput("br_stallcnt", {28'd0, StallCnt}, 32'd0);

    // Stall beats jump
    normalCycle(32'h0040_0200);
    applyStimulus(1, 32'h0040_0204, $urandom, 1, 1, 0);
    checkOutput("stall_vs_jump_flush", {28'd0, FlushCnt}, 32'd1);
    checkOutput("stall_vs_jump_valid", {31'd0, IF_ID_Valid}, 32'd1);

    // Jump flush, then a hazard against the empty slot is ignored
    applyStimulus(1, 32'h0040_0204, $urandom, 0, 1, 0);
    applyStimulus(1, 32'h0040_0300, 32'h1234_5678, 1, 0, 0);
    checkOutput("invalid_slot_load", IF_ID_Instr, 32'h1234_5678);

    // Isolated stalls saturate the stall counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h0050_0000, $urandom, 1, 0, 0);
      normalCycle(32'h0050_0000 + 32'(i * 4));
    end
    checkOutput("stallcnt_sat", {28'd0, StallCnt}, 32'd15);

    // PC+4 wraps at the top of the address space
    normalCycle(32'hFFFF_FFFC);
    checkOutput("pc4_wrap", IF_ID_PCPlus4, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0), $urandom, $urandom,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
